// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential multiplier.
// Holds the FSM state enum and the operand, counter and latency sizing.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        FIX  = 2'd3
    } state_t;

    localparam int MUL_N     = 32;
    localparam int MUL_CNT_W = 6;
    localparam int MUL_LAT   = 32;

endpackage

// File: rtl/add_32.sv
// Library 32-bit ripple-carry adder.
// Ports: a, b, i_carry in; o_result, o_carry, o_overflow (signed) out.
module add_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        i_carry,
    output logic [31:0] o_result,
    output logic        o_carry,
    output logic        o_overflow
);

    logic [32:0] c;

    always_comb begin
        c        = '0;
        o_result = '0;
        c[0]     = i_carry;
        for (int i = 0; i < 32; i++) begin
            o_result[i] = a[i] ^ b[i] ^ c[i];
            c[i+1]      = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign o_carry    = c[32];
    assign o_overflow = c[32] ^ c[31];

endmodule

// File: rtl/mul_seq_32.sv
// Multi-cycle 32x32->64 shift-and-add multiplier on one add_32 instance.
// Ports: i_valid/o_ready operands i_a,i_b; o_valid/i_ready result
// o_product, o_hi_nz; i_abort cancels RUN; o_busy. Macro
// MUL_SEQ_SIGNED_EN adds i_signed and a FIX (negate) cycle.
import mul_pkg::*;

module mul_seq_32 #(
    parameter int N     = MUL_N,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [N-1:0]  i_a,
    input  logic [N-1:0]  i_b,
`ifdef MUL_SEQ_SIGNED_EN
    input  logic          i_signed,
`endif
    input  logic          i_abort,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [2*N-1:0] o_product,
    output logic          o_hi_nz,
    output logic          o_busy
);

    state_t state, state_n;

    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     acc_hi;
    logic [N-1:0]     mplr;
    logic [N-1:0]     mcand;

    logic [N-1:0] add_b;
    logic [N-1:0] add_sum;
    logic         add_co;
    logic         add_ovf;

    logic [N-1:0]   acc_n;
    logic [N-1:0]   mplr_n;
    logic [2*N-1:0] prod_n;
    logic           last;
    logic           go_fix;

`ifdef MUL_SEQ_SIGNED_EN
    logic           sgn_mode;
    logic           sign;
    logic [2*N-1:0] prod_fix;
    logic [N-1:0]   a_in;
    logic [N-1:0]   b_in;
`endif

    assign add_b = mplr[0] ? mcand : '0;

    add_32 u_add (
        .a          (acc_hi),
        .b          (add_b),
        .i_carry    (1'b0),
        .o_result   (add_sum),
        .o_carry    (add_co),
        .o_overflow (add_ovf)
    );

    // {carry,sum,mplr} >> 1: the sum LSB shifts into the multiplier
    assign acc_n  = {add_co, add_sum[N-1:1]};
    assign mplr_n = {add_sum[0], mplr[N-1:1]};
    assign prod_n = {acc_n, mplr_n};
    assign last   = (cnt == CNT_W'(MUL_LAT - 1));

`ifdef MUL_SEQ_SIGNED_EN
    assign go_fix   = sgn_mode;
    assign prod_fix = sign ? (~{acc_hi, mplr} + 64'd1)
                           : {acc_hi, mplr};
    assign a_in = (i_signed & i_a[N-1]) ? (~i_a + 1'b1) : i_a;
    assign b_in = (i_signed & i_b[N-1]) ? (~i_b + 1'b1) : i_b;
`else
    assign go_fix = 1'b0;
`endif

    assign o_ready = (state == IDLE);
    assign o_busy  = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (i_valid) state_n = RUN;
            RUN: begin
                if (i_abort)     state_n = IDLE;
                else if (last)   state_n = go_fix ? FIX : DONE;
            end
            DONE: if (i_ready) state_n = IDLE;
`ifdef MUL_SEQ_SIGNED_EN
            FIX: state_n = DONE;
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            acc_hi    <= '0;
            mplr      <= '0;
            mcand     <= '0;
            o_product <= '0;
            o_hi_nz   <= 1'b0;
            o_valid   <= 1'b0;
`ifdef MUL_SEQ_SIGNED_EN
            sgn_mode  <= 1'b0;
            sign      <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_valid) begin
`ifdef MUL_SEQ_SIGNED_EN
                        mcand    <= a_in;
                        mplr     <= b_in;
                        sgn_mode <= i_signed;
                        sign     <= i_signed & (i_a[N-1] ^ i_b[N-1]);
`else
                        mcand    <= i_a;
                        mplr     <= i_b;
`endif
                        acc_hi   <= '0;
                        cnt      <= '0;
                    end
                end
                RUN: begin
                    if (!i_abort) begin
                        acc_hi <= acc_n;
                        mplr   <= mplr_n;
                        cnt    <= cnt + 1'b1;
                        if (last && !go_fix) begin
                            o_product <= prod_n;
                            o_hi_nz   <= |prod_n[2*N-1:N];
                            o_valid   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (i_ready) o_valid <= 1'b0;
                end
`ifdef MUL_SEQ_SIGNED_EN
                FIX: begin
                    o_product <= prod_fix;
                    o_hi_nz   <= prod_fix[2*N-1:N] != {N{prod_fix[N-1]}};
                    o_valid   <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_32.sv
// Directed self-checking bench for mul_seq_32.
// Scenarios: reset, latency, max operands, back-pressure, abort, async reset.
module tb_mul_seq_32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        i_abort;
    logic        o_valid;
    logic        i_ready;
    logic [63:0] o_product;
    logic        o_hi_nz;
    logic        o_busy;
`ifdef MUL_SEQ_SIGNED_EN
    logic        i_signed;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mul_seq_32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_a       (i_a),
        .i_b       (i_b),
`ifdef MUL_SEQ_SIGNED_EN
        .i_signed  (i_signed),
`endif
        .i_abort   (i_abort),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_product (o_product),
        .o_hi_nz   (o_hi_nz),
        .o_busy    (o_busy)
    );

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        i_a = a;
        i_b = b;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        i_a = 32'hDEAD_BEEF;
        i_b = 32'h1234_5678;
    endtask

    task automatic wait_result(output int cycles);
        cycles = 0;
        while (!o_valid && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic consume();
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if (o_valid !== 1'b0 || o_product !== 64'd0 || o_hi_nz !== 1'b0
            || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_outs v=%b p=%h h=%b b=%b exp all 0",
                     o_valid, o_product, o_hi_nz, o_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (o_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b exp=1", o_ready);
        end
    endtask

    task automatic test_basic();
        int cyc;
        start(32'd3, 32'd5);
        wait_result(cyc);
        total++;
        if (cyc !== 32) begin
            bad++;
            $display("FAIL basic_lat got=%0d exp=32", cyc);
        end
        total++;
        if (o_product !== 64'h0000_0000_0000_000F || o_hi_nz !== 1'b0) begin
            bad++;
            $display("FAIL basic_prod got=%h/%b exp=%h/0",
                     o_product, o_hi_nz, 64'hF);
        end
        consume();
        total++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_consume v=%b r=%b exp 0/1", o_valid, o_ready);
        end
    endtask

    task automatic test_max();
        int cyc;
        start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result(cyc);
        total++;
        if (o_product !== 64'hFFFF_FFFE_0000_0001 || o_hi_nz !== 1'b1
            || cyc !== 32) begin
            bad++;
            $display("FAIL max_prod got=%h/%b/%0d exp=%h/1/32",
                     o_product, o_hi_nz, cyc, 64'hFFFF_FFFE_0000_0001);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int cyc;
        int bp_bad = 0;
        start(32'h0001_0000, 32'h0001_0000);
        wait_result(cyc);
        i_valid = 1'b1;
        i_a = 32'd6;
        i_b = 32'd7;
        for (int k = 0; k < 10; k++) begin
            if (o_valid !== 1'b1 || o_ready !== 1'b0
                || o_product !== 64'h0000_0001_0000_0000 || o_hi_nz !== 1'b1)
                bp_bad++;
            @(negedge clk);
        end
        total++;
        if (bp_bad != 0) begin
            bad++;
            $display("FAIL bp_stable bad_cycles=%0d exp=0 p=%h v=%b r=%b",
                     bp_bad, o_product, o_valid, o_ready);
        end
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        total++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_handshake v=%b r=%b b=%b exp 0/1/0",
                     o_valid, o_ready, o_busy);
        end
        @(negedge clk);
        i_valid = 1'b0;
        total++;
        if (o_busy !== 1'b1) begin
            bad++;
            $display("FAIL bp_accept busy=%b exp=1", o_busy);
        end
        wait_result(cyc);
        total++;
        if (o_product !== 64'd42 || cyc !== 32) begin
            bad++;
            $display("FAIL bp_second got=%h/%0d exp=%h/32",
                     o_product, cyc, 64'd42);
        end
        consume();
    endtask

    task automatic test_abort();
        int cyc;
        start(32'd100, 32'd100);
        repeat (14) @(negedge clk);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        total++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_ready !== 1'b1
            || o_product !== 64'd42) begin
            bad++;
            $display("FAIL abort_idle b=%b v=%b r=%b p=%h exp 0/0/1/%h",
                     o_busy, o_valid, o_ready, o_product, 64'd42);
        end
        start(32'd7, 32'd9);
        wait_result(cyc);
        total++;
        if (o_product !== 64'h3F || cyc !== 32) begin
            bad++;
            $display("FAIL abort_next got=%h/%0d exp=%h/32",
                     o_product, cyc, 64'h3F);
        end
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        total++;
        if (o_valid !== 1'b1 || o_product !== 64'h3F) begin
            bad++;
            $display("FAIL abort_done v=%b p=%h exp 1/%h",
                     o_valid, o_product, 64'h3F);
        end
        consume();
    endtask

    task automatic test_async_reset();
        int cyc;
        start(32'hFFFF_FFFF, 32'd3);
        wait_result(cyc);
        consume();
        start(32'h1234_5678, 32'h9ABC_DEF0);
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (o_valid !== 1'b0 || o_product !== 64'd0 || o_hi_nz !== 1'b0
            || o_busy !== 1'b0 || o_ready !== 1'b1) begin
            bad++;
            $display("FAIL areset_now v=%b p=%h h=%b b=%b r=%b exp 0/0/0/0/1",
                     o_valid, o_product, o_hi_nz, o_busy, o_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            bad++;
            $display("FAIL areset_release r=%b v=%b exp 1/0", o_ready, o_valid);
        end
    endtask

`ifdef MUL_SEQ_SIGNED_EN
    task automatic test_signed();
        int cyc;
        i_signed = 1'b1;
        start(32'hFFFF_FFFD, 32'd7);
        i_signed = 1'b0;
        wait_result(cyc);
        total++;
        if (o_product !== 64'hFFFF_FFFF_FFFF_FFEB || o_hi_nz !== 1'b0
            || cyc !== 33) begin
            bad++;
            $display("FAIL signed_prod got=%h/%b/%0d exp=%h/0/33",
                     o_product, o_hi_nz, cyc, 64'hFFFF_FFFF_FFFF_FFEB);
        end
        consume();
        start(32'hFFFF_FFFD, 32'd7);
        wait_result(cyc);
        total++;
        if (o_product !== 64'h0000_0006_FFFF_FFEB || o_hi_nz !== 1'b1
            || cyc !== 32) begin
            bad++;
            $display("FAIL unsigned_prod got=%h/%b/%0d exp=%h/1/32",
                     o_product, o_hi_nz, cyc, 64'h0000_0006_FFFF_FFEB);
        end
        consume();
    endtask
`endif

    initial begin
        i_valid = 1'b0;
        i_a = '0;
        i_b = '0;
        i_abort = 1'b0;
        i_ready = 1'b0;
`ifdef MUL_SEQ_SIGNED_EN
        i_signed = 1'b0;
`endif
        test_reset();
        test_basic();
        test_max();
        test_back_to_back();
        test_abort();
        test_async_reset();
`ifdef MUL_SEQ_SIGNED_EN
        test_signed();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
